fetch_unit: RTL and testbench

- Instruction-fetch and PC-sequencing stage of the multi-cycle RV32I core.
- Holds the PC and issues requests on a req/ack instruction-memory port.
- Latches the returned word into an instruction register. Instr[31:7] of that register feeds the immediate extender.
- Consumes the extender's ExtImm and the ALU result to form the next PC for branches, JAL and JALR.

---
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_unit.sv | 142 ++++++++++++++
 tb/tb_fetch_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
// Instruction-memory request/acknowledge port between the fetch stage and the
// instruction memory.
//
// Signals:
//   IMemReq    fetch request, driven by the fetch unit (registered there)
//   IMemAddr   fetch address, driven by the fetch unit (equals its PC)
//   IMemAck    memory has IMemRData valid this cycle
//   IMemRData  fetched instruction word
//
// Modports:
//   master  fetch unit side (drives request and address)
//   slave   memory side (drives acknowledge and read data)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemRData;

    modport master (
        output IMemReq,
        output IMemAddr,
        input  IMemAck,
        input  IMemRData
    );

    modport slave (
        input  IMemReq,
        input  IMemAddr,
        output IMemAck,
        output IMemRData
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch and PC-sequencing stage of the multi-cycle RV32I core.
// Holds the PC, fetches one instruction word at a time over a req/ack memory
// port, keeps it in the instruction register until the core retires it, and
// then forms the next PC (sequential, PC-relative branch/JAL, or JALR target).
// A misaligned next PC parks the unit in a terminal fault state.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   imem         instruction-memory port (master side of fetch_unit_if)
//   PCSrc        next-PC select: 00 PC+4, 01 PC+ExtImm,
//                10 {ALUResult[31:1],0}, 11 reserved (same as 00)
//   ExtImm       sign-extended immediate from the extender
//   ALUResult    JALR target (rs1+imm)
//   Retire       current instruction complete; advance PC
//   Instr        instruction register (Instr[31:7] feeds the extender)
//   InstrValid   Instr holds a fetched, not-yet-retired instruction
//   PC           address of Instr
//   PCPlus4      PC+4 (combinational), used for link writeback
//   MisalignErr  sticky instruction-address-misaligned fault
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    fetch_unit_if.master       imem,
    input  logic [1:0]         PCSrc,
    input  logic [31:0]        ExtImm,
    input  logic [31:0]        ALUResult,
    input  logic               Retire,
    output logic [31:0]        Instr,
    output logic               InstrValid,
    output logic [31:0]        PC,
    output logic [31:0]        PCPlus4,
    output logic               MisalignErr
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        imem_req;
    logic        misalign_err;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        next_pc_misaligned;

    // JALR clears bit 0 of the target, so ALUResult[0] never matters.
    logic unused_alu_lsb;
    assign unused_alu_lsb = ALUResult[0];

    // 32-bit modular add; 0xFFFFFFFC wraps to 0x00000000.
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        next_pc = pc_plus4;
        case (PCSrc)
            2'b01:   next_pc = pc + ExtImm;
            2'b10:   next_pc = {ALUResult[31:1], 1'b0};
            default: next_pc = pc_plus4;   // 00 and reserved 11
        endcase
    end

    // Bit 0 can only be set by a branch offset; bit 1 by either source.
    assign next_pc_misaligned = (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            pc           <= RESET_PC;
            instr        <= NOP;
            instr_valid  <= 1'b0;
            imem_req     <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // An ack seen here belongs to nothing we asked for.
                    imem_req <= 1'b1;
                    state    <= FETCH;
                end

                FETCH: begin
                    // Address is the PC, which cannot move while fetching,
                    // so it stays stable for however long memory stalls.
                    if (imem.IMemAck) begin
                        instr       <= imem.IMemRData;
                        instr_valid <= 1'b1;
                        imem_req    <= 1'b0;
                        state       <= EXEC;
                    end
                end

                EXEC: begin
                    if (Retire) begin
                        instr_valid <= 1'b0;
                        if (next_pc_misaligned) begin
                            // PC keeps the faulting instruction's address.
                            misalign_err <= 1'b1;
                            imem_req     <= 1'b0;
                            state        <= FAULT;
                        end else begin
                            // Go straight to the next fetch, no idle bubble.
                            pc       <= next_pc;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                        end
                    end
                end

                FAULT: begin
                    // Terminal: everything frozen until reset.
                end

                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

    assign imem.IMemReq  = imem_req;
    assign imem.IMemAddr = pc;
    assign Instr         = instr;
    assign InstrValid    = instr_valid;
    assign PC            = pc;
    assign PCPlus4       = pc_plus4;
    assign MisalignErr   = misalign_err;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [1:0]  PCSrc;
    logic [31:0] ExtImm;
    logic [31:0] ALUResult;
    logic        Retire;
    logic [31:0] Instr;
    logic        InstrValid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        MisalignErr;

    fetch_unit_if imem ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (imem),
        .PCSrc       (PCSrc),
        .ExtImm      (ExtImm),
        .ALUResult   (ALUResult),
        .Retire      (Retire),
        .Instr       (Instr),
        .InstrValid  (InstrValid),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .MisalignErr (MisalignErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic e_valid, input logic e_req, input logic e_err);
        chk({tag, " PC"},          PC,            e_pc);
        chk({tag, " IMemAddr"},    imem.IMemAddr, e_pc);
        chk({tag, " PCPlus4"},     PCPlus4,       e_pc + 32'd4);
        chk({tag, " Instr"},       Instr,         e_instr);
        chk({tag, " InstrValid"},  {31'd0, InstrValid},  {31'd0, e_valid});
        chk({tag, " IMemReq"},     {31'd0, imem.IMemReq}, {31'd0, e_req});
        chk({tag, " MisalignErr"}, {31'd0, MisalignErr}, {31'd0, e_err});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [1:0] src, input logic [31:0] ext, input logic [31:0] alu,
                          input logic ret, input logic ack, input logic [31:0] rd);
        PCSrc          = src;
        ExtImm         = ext;
        ALUResult      = alu;
        Retire         = ret;
        imem.IMemAck   = ack;
        imem.IMemRData = rd;
    endtask

    // Called just after an active edge; holds reset across one edge.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [1:0]  pcsrc;
        logic [31:0] ext;
        logic [31:0] alu;
        logic        retire;
        logic        ack;
        logic [31:0] rdata;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
        logic        exp_valid;
        logic        exp_req;
        logic        exp_err;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs[NV];

    // ---------------- behavioural reference model ----------------
    // Tracked as "has the unit started", "is a fetch outstanding",
    // "is an instruction held", "has it faulted".
    logic [31:0] m_pc, m_instr;
    logic        m_started, m_req, m_valid, m_err;

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h13;
        m_started = 0; m_req = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic model_edge();
        logic [31:0] tgt;
        if (m_err) begin
            // frozen
        end else if (!m_started) begin
            m_started = 1; m_req = 1;
        end else if (m_req) begin
            if (imem.IMemAck) begin
                m_instr = imem.IMemRData; m_valid = 1; m_req = 0;
            end
        end else if (m_valid && Retire) begin
            if (PCSrc == 2'd1)      tgt = m_pc + ExtImm;
            else if (PCSrc == 2'd2) tgt = ALUResult - (ALUResult % 2);
            else                    tgt = m_pc + 4;
            m_valid = 0;
            if (tgt % 4 == 0) begin
                m_pc = tgt; m_req = 1;
            end else begin
                m_err = 1;
            end
        end
    endtask

    initial begin
        int fault_cycles;
        reset = 1'b0;
        set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Program order: see comments on each row.
        vecs[0]  = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0,         32'h13,        0, 1, 0}; // idle->fetch, ack ignored
        vecs[1]  = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0050_0093, 32'h0,         32'h0050_0093, 1, 0, 0}; // 1-cycle fetch
        vecs[2]  = '{2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,         32'h4,         32'h0050_0093, 0, 1, 0}; // retire +4
        vecs[3]  = '{2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,         32'h4,         32'h0050_0093, 0, 1, 0}; // stall, spurious retire
        vecs[4]  = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1111_1111, 32'h4,         32'h1111_1111, 1, 0, 0};
        vecs[5]  = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h4,         32'h1111_1111, 1, 0, 0}; // spurious ack in exec
        vecs[6]  = '{2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,         32'h8,         32'h1111_1111, 0, 1, 0};
        vecs[7]  = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,         32'h8,         32'h1111_1111, 0, 1, 0};
        vecs[8]  = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h2222_2222, 32'h8,         32'h2222_2222, 1, 0, 0};
        vecs[9]  = '{2'd3, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,         32'hC,         32'h2222_2222, 0, 1, 0}; // reserved = +4
        vecs[10] = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,         32'hC,         32'h2222_2222, 0, 1, 0};
        vecs[11] = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h3333_3333, 32'hC,         32'h3333_3333, 1, 0, 0};
        vecs[12] = '{2'd1, 32'hF4, 32'h0, 1'b1, 1'b0, 32'h0,        32'h100,       32'h3333_3333, 0, 1, 0}; // branch to 0x100
        vecs[13] = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h4444_4444, 32'h100,       32'h4444_4444, 1, 0, 0};
        vecs[14] = '{2'd1, 32'hFFFF_FFF0, 32'h0, 1'b1, 1'b0, 32'h0, 32'hF0,        32'h4444_4444, 0, 1, 0}; // backward branch
        vecs[15] = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5555_5555, 32'hF0,        32'h5555_5555, 1, 0, 0};
        vecs[16] = '{2'd2, 32'h0, 32'h205, 1'b1, 1'b0, 32'h0,       32'h204,       32'h5555_5555, 0, 1, 0}; // JALR clears bit0
        vecs[17] = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h6666_6666, 32'h204,       32'h6666_6666, 1, 0, 0};
        vecs[18] = '{2'd2, 32'h0, 32'hFFFF_FFFD, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, 32'h6666_6666, 0, 1, 0};
        vecs[19] = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h7777_7777, 32'hFFFF_FFFC, 32'h7777_7777, 1, 0, 0};
        vecs[20] = '{2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h7777_7777, 0, 1, 0}; // wrap to 0
        vecs[21] = '{2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h8888_8888, 32'h0,         32'h8888_8888, 1, 0, 0};
        vecs[22] = '{2'd2, 32'h0, 32'h206, 1'b1, 1'b0, 32'h0,       32'h0,         32'h8888_8888, 0, 0, 1}; // misaligned JALR
        vecs[23] = '{2'd0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h9999_9999, 32'h0,         32'h8888_8888, 0, 0, 1}; // fault frozen

        // asynchronous reset value, checked before any clock edge
        #2;
        reset = 1'b1;
        #1;
        chk_all("reset", 32'h0, 32'h13, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            set_in(vecs[i].pcsrc, vecs[i].ext, vecs[i].alu, vecs[i].retire, vecs[i].ack, vecs[i].rdata);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_instr,
                    vecs[i].exp_valid, vecs[i].exp_req, vecs[i].exp_err);
        end

        // ---------------- reset in the middle of a fetch ----------------
        set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        pulse_reset();
        tick();                                               // -> FETCH @0
        set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
        tick();                                               // -> EXEC
        set_in(2'd0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();                                               // -> FETCH @4
        chk_all("midfetch pre", 32'h4, 32'h1234_5678, 0, 1, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("midfetch async", 32'h0, 32'h13, 0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0); // late ack
        tick();
        chk_all("late ack ignored", 32'h0, 32'h13, 0, 1, 0);
        set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b1, 32'hABCD_EF01);
        tick();
        chk_all("refetch", 32'h0, 32'hABCD_EF01, 1, 0, 0);

        // ---------------- randomized run against the model ----------------
        set_in(2'd0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        pulse_reset();
        model_reset();
        fault_cycles = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] ext, alu;
            ext = $urandom;
            alu = $urandom;
            if ($urandom_range(0, 7) != 0) ext[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) alu[1]   = 1'b0;
            set_in(2'($urandom_range(0, 3)), ext, alu, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom);
            model_edge();
            tick();
            chk_all($sformatf("rand%0d", c), m_pc, m_instr, m_valid, m_req, m_err);
            fault_cycles = m_err ? fault_cycles + 1 : 0;
            if (fault_cycles > 2 || $urandom_range(0, 99) == 0) begin
                pulse_reset();
                model_reset();
                fault_cycles = 0;
                chk_all($sformatf("rand%0d reset", c), m_pc, m_instr, m_valid, m_req, m_err);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
